// File: rtl/fetch_queue_if.sv
// Fetch/Decode handshake bundle for the instruction fetch queue.
// The queue sits on the slave side; Fetch/Decode (or a bench) drive the master side.
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int PTR_W = $clog2(DEPTH);

  logic              flush;
  logic              valid_in;
  logic [31:0]       instr_in;
  logic [31:0]       pc_in;
  logic [31:0]       pc_4_in;
  logic              ready_out;
  logic              valid_out;
  logic [31:0]       instr_out;
  logic [31:0]       pc_out;
  logic [31:0]       pc_4_out;
  logic              ready_in;
  logic [PTR_W:0]    count;

  modport slave (
    input  flush, valid_in, instr_in, pc_in, pc_4_in, ready_in,
    output ready_out, valid_out, instr_out, pc_out, pc_4_out, count
  );

  modport master (
    output flush, valid_in, instr_in, pc_in, pc_4_in, ready_in,
    input  ready_out, valid_out, instr_out, pc_out, pc_4_out, count
  );
endinterface

// File: rtl/fetch_queue.sv
// Circular instruction buffer between Fetch and Decode: {instr, pc, pc_4} entries,
// registered-only data path, single-cycle flush on redirect.
module fetch_queue #(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           reset,
  fetch_queue_if.slave   q
);

  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [95:0]      mem [DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [PTR_W:0]   count_q;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [95:0]      head_entry;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);

  // ready_out depends on occupancy only, so a full queue never passes through on a pop.
  assign push = q.valid_in && !full;
  assign pop  = !empty && q.ready_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (q.flush) begin
      // Storage is left stale; it stays hidden because valid_out drops.
      head_ptr <= '0;
      tail_ptr <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem[tail_ptr] <= {q.instr_in, q.pc_in, q.pc_4_in};
        tail_ptr      <= tail_ptr + PTR_ONE;
      end
      if (pop) begin
        head_ptr <= head_ptr + PTR_ONE;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    head_entry = '0;
    if (!empty) begin
      head_entry = mem[head_ptr];
    end
  end

  assign q.ready_out = !full;
  assign q.valid_out = !empty;
  assign q.instr_out = head_entry[95:64];
  assign q.pc_out    = head_entry[63:32];
  assign q.pc_4_out  = head_entry[31:0];
  assign q.count     = count_q;

endmodule
